// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one single-cycle memory between the CPU
// fetch path and a loader/debug port, with loader burst limiting and an exclusive lock.
module imem_arbiter #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stall_req,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_lock,
  output logic        ld_ack,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_LD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            ld_rd_q;
  logic            ld_err_q;

  logic            gnt_cpu_s;
  logic            gnt_ld_s;
  logic            ld_mis_s;
  logic            burst_full_s;

  assign ld_mis_s     = (ld_addr[1:0] != 2'b00);
  assign burst_full_s = (burst_q >= CW'(BURST_MAX));

  // Grant decision; reset suppresses every grant so no access leaks out of a reset cycle.
  always_comb begin
    gnt_cpu_s = 1'b0;
    gnt_ld_s  = 1'b0;
    if (rst) begin
      gnt_cpu_s = 1'b0;
      gnt_ld_s  = 1'b0;
    end else if (ld_lock) begin
      gnt_ld_s  = ld_req;
    end else if (ld_req && (!if_ce || !burst_full_s)) begin
      gnt_ld_s  = 1'b1;
    end else if (if_ce) begin
      gnt_cpu_s = 1'b1;
    end else begin
      gnt_cpu_s = 1'b0;
      gnt_ld_s  = 1'b0;
    end
  end

  // Next state and burst counter; the counter only tracks loader grants that keep the CPU waiting.
  always_comb begin
    state_d = S_IDLE;
    burst_d = burst_q;
    if (gnt_cpu_s) begin
      state_d = S_CPU;
    end else if (gnt_ld_s) begin
      state_d = S_LD;
    end else begin
      state_d = S_IDLE;
    end
    if (!if_ce || gnt_cpu_s) begin
      burst_d = '0;
    end else if (gnt_ld_s && !burst_full_s) begin
      burst_d = burst_q + CW'(1);
    end else begin
      burst_d = burst_q;
    end
  end

  // Arbiter state machine with the registered response qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      burst_q  <= '0;
      ld_rd_q  <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      ld_rd_q  <= gnt_ld_s & ~ld_we & ~ld_mis_s;
      ld_err_q <= gnt_ld_s & ld_mis_s;
    end
  end

  // Memory request mux; a misaligned loader access still reads but never writes.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    if (gnt_cpu_s) begin
      mem_ce    = 1'b1;
      mem_addr  = if_addr;
    end else if (gnt_ld_s) begin
      mem_ce    = 1'b1;
      mem_we    = ld_we & ~ld_mis_s;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else begin
      mem_ce    = 1'b0;
    end
  end

  // Responses follow the grant by one cycle; rst masks any response still in flight.
  always_comb begin
    stall_req = ~rst & if_ce & ~gnt_cpu_s;
    if_valid  = ~rst & (state_q == S_CPU);
    ld_ack    = ~rst & (state_q == S_LD);
    ld_err    = ld_ack & ld_err_q;
    if_inst   = if_valid ? mem_rdata : 32'h0000_0000;
    ld_rdata  = (ld_ack && ld_rd_q) ? mem_rdata : 32'h0000_0000;
  end

endmodule
